// File: rtl/er_pkg.sv
// Shared definitions for the Express Raider download path: ioctl index
// codes, the default region map and the router FSM state encoding.
package er_pkg;

  // ioctl_index values sent by the HPS
  localparam logic [7:0] IOCTL_IDX_ROM   = 8'h00;
  localparam logic [7:0] IOCTL_IDX_DIP   = 8'hFE;
  localparam logic [7:0] IOCTL_IDX_NVRAM = 8'hFF;

  // Default Express Raider ROM layout inside the .rom file (byte addresses)
  localparam int ER_AW   = 27;
  localparam int ER_NREG = 7;

  localparam logic [ER_AW-1:0] ER_MCPU_BASE = 27'h00000;
  localparam logic [ER_AW-1:0] ER_MCPU_SIZE = 27'h10000;
  localparam logic [ER_AW-1:0] ER_MAP_BASE  = 27'h10000;
  localparam logic [ER_AW-1:0] ER_MAP_SIZE  = 27'h08000;
  localparam logic [ER_AW-1:0] ER_CHAR_BASE = 27'h18000;
  localparam logic [ER_AW-1:0] ER_CHAR_SIZE = 27'h04000;
  localparam logic [ER_AW-1:0] ER_BG_BASE   = 27'h1C000;
  localparam logic [ER_AW-1:0] ER_BG_SIZE   = 27'h20000;
  localparam logic [ER_AW-1:0] ER_SPR_BASE  = 27'h3C000;
  localparam logic [ER_AW-1:0] ER_SPR_SIZE  = 27'h20000;
  localparam logic [ER_AW-1:0] ER_COL_BASE  = 27'h5C000;
  localparam logic [ER_AW-1:0] ER_COL_SIZE  = 27'h00400;
  localparam logic [ER_AW-1:0] ER_SND_BASE  = 27'h5C400;
  localparam logic [ER_AW-1:0] ER_SND_SIZE  = 27'h08000;

  // Flattened maps, region i at [i*ER_AW +: ER_AW] (highest index listed first)
  localparam logic [ER_NREG*ER_AW-1:0] ER_REG_BASE = {
    ER_SND_BASE, ER_COL_BASE, ER_SPR_BASE, ER_BG_BASE,
    ER_CHAR_BASE, ER_MAP_BASE, ER_MCPU_BASE
  };
  localparam logic [ER_NREG*ER_AW-1:0] ER_REG_SIZE = {
    ER_SND_SIZE, ER_COL_SIZE, ER_SPR_SIZE, ER_BG_SIZE,
    ER_CHAR_SIZE, ER_MAP_SIZE, ER_MCPU_SIZE
  };

  // Router FSM: LO/HI mean the low/high byte is on the write port this cycle
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2,
    ST_DRAIN = 2'd3
  } dl_state_t;

endpackage

// File: rtl/ioctl_region_dec.sv
// Combinational byte-address decoder: picks the lowest enabled region that
// contains addr, returns it one-hot with the byte offset inside it and a
// flag telling whether addr is that region's last byte.
module ioctl_region_dec
  import er_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW   = 27,
  parameter int OW   = 16,
  parameter logic [NREG*AW-1:0] REG_BASE = '0,
  parameter logic [NREG*AW-1:0] REG_SIZE = '0
) (
  input  logic [AW-1:0]   addr,
  output logic [NREG-1:0] sel,
  output logic [NREG-1:0] last,
  output logic [OW-1:0]   offset
);

  logic [NREG-1:0] w_hit;
  logic [NREG-1:0] w_end;
  logic [OW-1:0]   w_off [NREG];

  // Per-region range test; the limit is one bit wider so base+size never wraps
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic [AW-1:0] w_base;
      logic [AW-1:0] w_size;
      logic [AW:0]   w_lim;
      assign w_base     = REG_BASE[gi*AW +: AW];
      assign w_size     = REG_SIZE[gi*AW +: AW];
      assign w_lim      = {1'b0, w_base} + {1'b0, w_size};
      assign w_hit[gi]  = (w_size != '0) && (addr >= w_base) &&
                          ({1'b0, addr} < w_lim);
      assign w_end[gi]  = (({1'b0, addr} + {{AW{1'b0}}, 1'b1}) == w_lim);
      assign w_off[gi]  = OW'(addr - w_base);
    end
  endgenerate

  // Priority select: scan downwards so the lowest matching index wins
  always_comb begin
    sel    = '0;
    offset = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        offset = w_off[i];
      end
    end
    last = sel & w_end;
  end

endmodule

// File: rtl/ioctl_rom_router.sv
// Routes the HPS ioctl download stream to per-region ROM byte write ports.
// Each accepted word is serialised into one or two byte writes while
// ioctl_wait holds the HPS off; completion, checksum and errors are tracked
// per download.
module ioctl_rom_router
  import er_pkg::*;
#(
  parameter int NREG = 4,
  parameter int AW   = 27,
  parameter int OW   = 16,
  parameter bit WIDE = 1'b1,
  parameter logic [7:0] ROM_INDEX = IOCTL_IDX_ROM,
  parameter logic [NREG*AW-1:0] REG_BASE = '0,
  parameter logic [NREG*AW-1:0] REG_SIZE = '0
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_download,
  input  logic [AW-1:0]   ioctl_addr,
  input  logic [15:0]     ioctl_dout,
  input  logic            ioctl_wr,
  output logic            ioctl_wait,
  output logic [NREG-1:0] rom_we,
  output logic [OW-1:0]   rom_addr,
  output logic [7:0]      rom_data,
  output logic [NREG-1:0] loaded,
  output logic            dl_done,
  output logic [15:0]     checksum,
  output logic [1:0]      err
);

  dl_state_t       r_state;
  dl_state_t       w_state_next;
  logic            r_active_d;
  logic            r_pend;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_hi;
  logic            r_wait;
  logic [NREG-1:0] r_we;
  logic [OW-1:0]   r_rom_addr;
  logic [7:0]      r_rom_data;
  logic [NREG-1:0] r_loaded;
  logic            r_dl_done;
  logic [15:0]     r_checksum;
  logic [1:0]      r_err;

  logic            w_active;
  logic            w_rise;
  logic            w_fall;
  logic            w_accept;
  logic            w_overrun;
  logic            w_emit;
  logic [AW-1:0]   w_emit_addr;
  logic [7:0]      w_emit_data;
  logic            w_idle_done;
  logic            w_pend_next;
  logic            w_wait_next;
  logic            w_done_next;
  logic [NREG-1:0] w_sel;
  logic [NREG-1:0] w_last;
  logic [OW-1:0]   w_off;
  logic [NREG-1:0] w_we;
  logic [NREG-1:0] w_loaded_set;
  logic            w_unmapped;

  assign w_active  = ioctl_download && (ioctl_index == ROM_INDEX);
  assign w_rise    = w_active && !r_active_d;
  assign w_fall    = !w_active && r_active_d;
  assign w_accept  = (r_state == ST_IDLE) && ioctl_wr && w_active;
  assign w_overrun = (r_state != ST_IDLE) && ioctl_wr && w_active;

  // Next state and the byte to emit at the coming edge; outputs are
  // registered, so the byte chosen here is visible one cycle later
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_emit_addr  = ioctl_addr;
    w_emit_data  = ioctl_dout[7:0];
    w_idle_done  = 1'b0;
    w_pend_next  = r_pend;
    case (r_state)
      ST_IDLE: begin
        w_pend_next = 1'b0;
        if (w_accept) begin
          w_state_next = ST_LO;
          w_emit       = 1'b1;
        end else if (w_fall) begin
          w_idle_done = 1'b1;
        end
      end
      ST_LO: begin
        if (WIDE) begin
          w_state_next = ST_HI;
          w_emit       = 1'b1;
          w_emit_addr  = r_addr + AW'(1);
          w_emit_data  = r_hi;
          w_pend_next  = r_pend || w_fall;
        end else begin
          w_state_next = (r_pend || w_fall) ? ST_DRAIN : ST_IDLE;
          w_pend_next  = 1'b0;
        end
      end
      ST_HI: begin
        w_state_next = (r_pend || w_fall) ? ST_DRAIN : ST_IDLE;
        w_pend_next  = 1'b0;
      end
      ST_DRAIN: begin
        w_state_next = ST_IDLE;
        w_pend_next  = 1'b0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_pend_next  = 1'b0;
      end
    endcase
  end

  assign w_wait_next  = (w_state_next == ST_LO) || (w_state_next == ST_HI);
  assign w_done_next  = w_idle_done || (w_state_next == ST_DRAIN);
  assign w_we         = w_emit ? w_sel : '0;
  assign w_loaded_set = w_emit ? w_last : '0;
  assign w_unmapped   = w_emit && (w_sel == '0);

  ioctl_region_dec #(
    .NREG     (NREG),
    .AW       (AW),
    .OW       (OW),
    .REG_BASE (REG_BASE),
    .REG_SIZE (REG_SIZE)
  ) u_dec (
    .addr   (w_emit_addr),
    .sel    (w_sel),
    .last   (w_last),
    .offset (w_off)
  );

  // State, byte port and per-download bookkeeping; a rising edge of active
  // starts a fresh download by clearing checksum, loaded and err
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_active_d <= 1'b0;
      r_pend     <= 1'b0;
      r_addr     <= '0;
      r_hi       <= '0;
      r_wait     <= 1'b0;
      r_we       <= '0;
      r_rom_addr <= '0;
      r_rom_data <= '0;
      r_loaded   <= '0;
      r_dl_done  <= 1'b0;
      r_checksum <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_active_d <= w_active;
      r_pend     <= w_pend_next;
      if (w_accept) begin
        r_addr <= ioctl_addr;
        r_hi   <= ioctl_dout[15:8];
      end
      r_wait    <= w_wait_next;
      r_we      <= w_we;
      if (w_emit) begin
        r_rom_addr <= w_off;
        r_rom_data <= w_emit_data;
      end
      r_dl_done  <= w_done_next;
      r_checksum <= (w_rise ? 16'h0 : r_checksum) +
                    ((|w_we) ? {8'h00, w_emit_data} : 16'h0);
      r_loaded   <= (w_rise ? '0 : r_loaded) | w_loaded_set;
      r_err      <= (w_rise ? 2'b00 : r_err) | {w_overrun, w_unmapped};
    end
  end

  assign ioctl_wait = r_wait;
  assign rom_we     = r_we;
  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign loaded     = r_loaded;
  assign dl_done    = r_dl_done;
  assign checksum   = r_checksum;
  assign err        = r_err;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed bench for ioctl_rom_router: four regions, 16-bit stream.
module tb_ioctl_rom_router;

  localparam int NREG = 4;
  localparam int AW   = 27;
  localparam int OW   = 16;
  localparam logic [NREG*AW-1:0] BASE = {27'h10000, 27'h0C000, 27'h08000, 27'h00000};
  localparam logic [NREG*AW-1:0] SIZE = {27'h00100, 27'h04000, 27'h04000, 27'h08000};

  logic            clk_sys = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      ioctl_index = 8'h00;
  logic            ioctl_download = 1'b0;
  logic [AW-1:0]   ioctl_addr = '0;
  logic [15:0]     ioctl_dout = '0;
  logic            ioctl_wr = 1'b0;
  logic            ioctl_wait;
  logic [NREG-1:0] rom_we;
  logic [OW-1:0]   rom_addr;
  logic [7:0]      rom_data;
  logic [NREG-1:0] loaded;
  logic            dl_done;
  logic [15:0]     checksum;
  logic [1:0]      err;

  int n_checks = 0;
  int n_err    = 0;

  ioctl_rom_router #(
    .NREG(NREG), .AW(AW), .OW(OW), .WIDE(1'b1), .ROM_INDEX(8'h00),
    .REG_BASE(BASE), .REG_SIZE(SIZE)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_index(ioctl_index),
    .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .loaded(loaded), .dl_done(dl_done), .checksum(checksum), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents one word for one cycle; returns in the cycle its low byte shows
  task automatic put_word(input logic [AW-1:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic word_idle(input logic [AW-1:0] a, input logic [15:0] d);
    put_word(a, d);
    tick();
    tick();
  endtask

  initial begin
    // reset values
    tick(); tick();
    check("rst_we", 32'(rom_we), 32'h0);
    check("rst_wait", 32'(ioctl_wait), 32'h0);
    check("rst_addr", 32'(rom_addr), 32'h0);
    check("rst_data", 32'(rom_data), 32'h0);
    check("rst_loaded", 32'(loaded), 32'h0);
    check("rst_done", 32'(dl_done), 32'h0);
    check("rst_csum", 32'(checksum), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    reset = 1'b0;
    tick();

    // write while no download is active is ignored
    put_word(27'h10, 16'hFFFF);
    check("inact_we", 32'(rom_we), 32'h0);
    check("inact_wait", 32'(ioctl_wait), 32'h0);
    check("inact_err", 32'(err), 32'h0);

    // basic word
    ioctl_download = 1'b1;
    tick();
    put_word(27'h10, 16'hBEEF);
    check("basic_we_lo", 32'(rom_we), 32'h1);
    check("basic_addr_lo", 32'(rom_addr), 32'h10);
    check("basic_data_lo", 32'(rom_data), 32'hEF);
    check("basic_wait1", 32'(ioctl_wait), 32'h1);
    tick();
    check("basic_we_hi", 32'(rom_we), 32'h1);
    check("basic_addr_hi", 32'(rom_addr), 32'h11);
    check("basic_data_hi", 32'(rom_data), 32'hBE);
    check("basic_wait2", 32'(ioctl_wait), 32'h1);
    check("basic_csum", 32'(checksum), 32'h01AD);
    tick();
    check("basic_we_end", 32'(rom_we), 32'h0);
    check("basic_wait3", 32'(ioctl_wait), 32'h0);

    // word straddling region0/region1
    put_word(27'h7FFF, 16'h1234);
    check("strad_we0", 32'(rom_we), 32'h1);
    check("strad_off0", 32'(rom_addr), 32'h7FFF);
    check("strad_d0", 32'(rom_data), 32'h34);
    check("strad_loaded", 32'(loaded), 32'h1);
    tick();
    check("strad_we1", 32'(rom_we), 32'h2);
    check("strad_off1", 32'(rom_addr), 32'h0);
    check("strad_d1", 32'(rom_data), 32'h12);
    check("strad_csum", 32'(checksum), 32'h01F3);
    tick();

    // unmapped word
    put_word(27'hF00000, 16'h5555);
    check("unm_we0", 32'(rom_we), 32'h0);
    check("unm_err", 32'(err), 32'h1);
    tick();
    check("unm_we1", 32'(rom_we), 32'h0);
    check("unm_csum", 32'(checksum), 32'h01F3);
    tick();

    // end of download from idle, then new download clears state
    ioctl_download = 1'b0;
    tick();
    check("fall_done", 32'(dl_done), 32'h1);
    check("fall_err_sticky", 32'(err), 32'h1);
    tick();
    check("fall_done_once", 32'(dl_done), 32'h0);
    ioctl_download = 1'b1;
    tick();
    check("rise_err", 32'(err), 32'h0);
    check("rise_csum", 32'(checksum), 32'h0);
    check("rise_loaded", 32'(loaded), 32'h0);

    // overrun: second write one cycle after the first
    put_word(27'h20, 16'hA55A);
    ioctl_addr = 27'h40;
    ioctl_dout = 16'h1111;
    ioctl_wr   = 1'b1;
    check("ovr_we_lo", 32'(rom_we), 32'h1);
    check("ovr_addr_lo", 32'(rom_addr), 32'h20);
    check("ovr_data_lo", 32'(rom_data), 32'h5A);
    tick();
    ioctl_wr = 1'b0;
    check("ovr_err", 32'(err), 32'h2);
    check("ovr_we_hi", 32'(rom_we), 32'h1);
    check("ovr_addr_hi", 32'(rom_addr), 32'h21);
    check("ovr_data_hi", 32'(rom_data), 32'hA5);
    tick();
    check("ovr_we_end", 32'(rom_we), 32'h0);
    tick();
    check("ovr_dropped", 32'(rom_we), 32'h0);
    check("ovr_csum", 32'(checksum), 32'h00FF);

    // full load of all regions, download falls mid-word
    word_idle(27'h7FFE, 16'h0102);
    word_idle(27'hBFFE, 16'h0304);
    word_idle(27'hFFFE, 16'h0506);
    put_word(27'h100FE, 16'h0708);
    ioctl_download = 1'b0;
    check("full_we_lo", 32'(rom_we), 32'h8);
    check("full_addr_lo", 32'(rom_addr), 32'hFE);
    check("full_data_lo", 32'(rom_data), 32'h08);
    check("full_loaded_lo", 32'(loaded), 32'h7);
    tick();
    check("full_we_hi", 32'(rom_we), 32'h8);
    check("full_addr_hi", 32'(rom_addr), 32'hFF);
    check("full_data_hi", 32'(rom_data), 32'h07);
    check("full_loaded", 32'(loaded), 32'hF);
    check("full_wait_hi", 32'(ioctl_wait), 32'h1);
    check("full_done_early", 32'(dl_done), 32'h0);
    tick();
    check("full_done", 32'(dl_done), 32'h1);
    check("full_we_drain", 32'(rom_we), 32'h0);
    check("full_wait_drain", 32'(ioctl_wait), 32'h0);
    check("full_csum", 32'(checksum), 32'h0123);
    tick();
    check("full_done_once", 32'(dl_done), 32'h0);
    check("full_loaded_hold", 32'(loaded), 32'hF);
    tick();
    check("full_done_quiet", 32'(dl_done), 32'h0);

    // reset while the low byte is on the port
    ioctl_download = 1'b1;
    tick();
    check("rst2_loaded_clr", 32'(loaded), 32'h0);
    put_word(27'h30, 16'h9999);
    check("rst2_we_lo", 32'(rom_we), 32'h1);
    reset = 1'b1;
    tick();
    check("rst2_we", 32'(rom_we), 32'h0);
    check("rst2_wait", 32'(ioctl_wait), 32'h0);
    check("rst2_addr", 32'(rom_addr), 32'h0);
    check("rst2_data", 32'(rom_data), 32'h0);
    check("rst2_csum", 32'(checksum), 32'h0);
    check("rst2_done", 32'(dl_done), 32'h0);
    reset = 1'b0;
    tick();
    check("rst2_we_after", 32'(rom_we), 32'h0);
    check("rst2_done_after", 32'(dl_done), 32'h0);
    tick();
    check("rst2_no_hi", 32'(rom_we), 32'h0);
    check("rst2_done_after2", 32'(dl_done), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
